// File: rtl/pwd_ctrl_pkg.sv
// Shared types and LED codes for the attempt lockout controller.
// LED codes are active-low RGB: a 0 bit lights that colour.
package pwd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    COOLDOWN = 3'd2,
    LOCKOUT  = 3'd3,
    GRANTED  = 3'd4
  } state_t;

  localparam logic [2:0] LED_OFF   = 3'b111;
  localparam logic [2:0] LED_RED   = 3'b110;
  localparam logic [2:0] LED_GREEN = 3'b101;
  localparam logic [2:0] LED_ALL   = 3'b000;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw button line plus a registered rising-edge pulse.
// The pulse appears two cycles after the raw rise is first sampled.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= raw;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end

  assign level = sync;

endmodule

// File: rtl/attempt_lockout_ctrl.sv
// Access controller: Enter press launches an external check; failures cause cooldown, then lockout.
// Define GLITCH_GUARD_EN to make a synchronised glitch_btn abort any check as a failure.
module attempt_lockout_ctrl
  import pwd_ctrl_pkg::*;
#(
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned COOLDOWN_CYCLES = 48_000_000,
  parameter int unsigned LOCKOUT_CYCLES  = 480_000_000,
  parameter int unsigned CHECK_TIMEOUT   = 100_000_000,
  parameter int unsigned BLINK_PERIOD    = 6_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_btn,
  input  logic       glitch_btn,
  output logic       chk_start,
  input  logic       chk_done,
  input  logic       chk_pass,
  output logic       granted,
  output logic       locked,
  output logic [3:0] fail_count,
  output logic [2:0] led
);

  localparam logic [3:0]  MAX_W      = 4'(MAX_FAILS);
  localparam logic [31:0] TIMEOUT_W  = 32'(CHECK_TIMEOUT);
  localparam logic [31:0] COOL_LAST  = 32'(COOLDOWN_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST  = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_PERIOD - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  count_next;
  logic [31:0] cnt;
  logic [31:0] blink_cnt;
  logic        blink_off;
  logic        press;
  logic        check_fail;
  logic        glitch_abort;
  logic        unused_enter_level;

  btn_sync_edge u_enter_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (enter_btn),
    .level (unused_enter_level),
    .rise  (press)
  );

`ifdef GLITCH_GUARD_EN
  logic glitch_level;
  logic unused_glitch_rise;

  btn_sync_edge u_glitch_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (glitch_btn),
    .level (glitch_level),
    .rise  (unused_glitch_rise)
  );

  assign glitch_abort = glitch_level;
`else
  logic unused_glitch_btn;

  assign unused_glitch_btn = glitch_btn;
  assign glitch_abort      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fail_count <= 4'd0;
    end else begin
      state      <= state_next;
      fail_count <= count_next;
    end
  end

  // Glitch abort beats a verdict, and a verdict beats a timeout in the same cycle.
  always_comb begin
    state_next = state;
    count_next = fail_count;
    check_fail = 1'b0;
    case (state)
      IDLE: begin
        if (press) state_next = CHECK;
      end
      CHECK: begin
        if (glitch_abort) begin
          check_fail = 1'b1;
        end else if (chk_done) begin
          if (chk_pass) begin
            state_next = GRANTED;
            count_next = 4'd0;
          end else begin
            check_fail = 1'b1;
          end
        end else if (cnt == TIMEOUT_W) begin
          check_fail = 1'b1;
        end
        if (check_fail) begin
          count_next = fail_count + 4'd1;
          state_next = (count_next == MAX_W) ? LOCKOUT : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cnt == COOL_LAST) state_next = IDLE;
      end
      LOCKOUT: begin
        if (cnt == LOCK_LAST) begin
          state_next = IDLE;
          count_next = 4'd0;
        end
      end
      GRANTED: begin
        if (press) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Both duration counters restart on every state change so each state sees cycle 0 on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 32'd0;
      blink_cnt <= 32'd0;
      blink_off <= 1'b0;
    end else if (state_next != state) begin
      cnt       <= 32'd0;
      blink_cnt <= 32'd0;
      blink_off <= 1'b0;
    end else begin
      cnt <= cnt + 32'd1;
      if (state == LOCKOUT) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= 32'd0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 32'd1;
        end
      end
    end
  end

  assign chk_start = (state == CHECK) && (cnt == 32'd0);
  assign granted   = (state == GRANTED);
  assign locked    = (state == LOCKOUT);

  always_comb begin
    led = LED_OFF;
    case (state)
      IDLE:     led = LED_OFF;
      CHECK:    led = LED_RED;
      COOLDOWN: led = LED_ALL;
      LOCKOUT:  led = blink_off ? LED_OFF : LED_RED;
      GRANTED:  led = LED_GREEN;
      default:  led = LED_OFF;
    endcase
  end

endmodule

// File: tb/tb_attempt_lockout_ctrl.sv
// Directed testbench for attempt_lockout_ctrl with short durations.
// Build with GLITCH_GUARD_EN defined to exercise the glitch-abort variant.
module tb_attempt_lockout_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_btn = 1'b0;
  logic       glitch_btn = 1'b0;
  logic       chk_done = 1'b0;
  logic       chk_pass = 1'b0;
  logic       chk_start;
  logic       granted;
  logic       locked;
  logic [3:0] fail_count;
  logic [2:0] led;

  int total = 0;
  int bad = 0;

  attempt_lockout_ctrl #(
    .MAX_FAILS       (3),
    .COOLDOWN_CYCLES (16),
    .LOCKOUT_CYCLES  (64),
    .CHECK_TIMEOUT   (32),
    .BLINK_PERIOD    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enter_btn  (enter_btn),
    .glitch_btn (glitch_btn),
    .chk_start  (chk_start),
    .chk_done   (chk_done),
    .chk_pass   (chk_pass),
    .granted    (granted),
    .locked     (locked),
    .fail_count (fail_count),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    enter_btn = 1'b0;
    glitch_btn = 1'b0;
    chk_done = 1'b0;
    chk_pass = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits for IDLE, raises Enter and returns at the negedge where chk_start is seen (lat=0 if never).
  task automatic press_wait_start(output int lat);
    int w;
    w = 0;
    while (led !== 3'b111 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    enter_btn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (chk_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    enter_btn = 1'b0;
  endtask

  task automatic fail_once(output int lat);
    press_wait_start(lat);
    chk_done = 1'b1;
    chk_pass = 1'b0;
    @(negedge clk);
    chk_done = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    int seen;
    rst = 1'b1;
    #1;
    total++; if (chk_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_chk_start: got %b want 0", chk_start); end
    total++; if (granted !== 1'b0) begin bad++; $display("[TB] FAIL reset_granted: got %b want 0", granted); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
    total++; if (fail_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_fail_count: got %0d want 0", fail_count); end
    total++; if (led !== 3'b111) begin bad++; $display("[TB] FAIL reset_led: got %b want 111", led); end
    do_reset();
    press_wait_start(lat);
    total++; if (lat != 4) begin bad++; $display("[TB] FAIL reset_first_press_latency: got %0d want 4", lat); end
    rst = 1'b1;
    #1;
    total++; if (led !== 3'b111) begin bad++; $display("[TB] FAIL reset_mid_check_led: got %b want 111", led); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (chk_start === 1'b1 || fail_count !== 4'd0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL reset_mid_check_residue: got %0d events want 0", seen); end
  endtask

  task automatic test_grant();
    int lat;
    do_reset();
    press_wait_start(lat);
    total++; if (lat != 4) begin bad++; $display("[TB] FAIL grant_start_latency: got %0d want 4", lat); end
    total++; if (led !== 3'b110) begin bad++; $display("[TB] FAIL grant_check_led: got %b want 110", led); end
    repeat (5) @(negedge clk);
    chk_done = 1'b1;
    chk_pass = 1'b1;
    @(negedge clk);
    chk_done = 1'b0;
    chk_pass = 1'b0;
    total++; if (granted !== 1'b1) begin bad++; $display("[TB] FAIL grant_granted: got %b want 1", granted); end
    total++; if (led !== 3'b101) begin bad++; $display("[TB] FAIL grant_led: got %b want 101", led); end
    total++; if (fail_count !== 4'd0) begin bad++; $display("[TB] FAIL grant_fail_count: got %0d want 0", fail_count); end
    repeat (6) @(negedge clk);
    enter_btn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (granted !== 1'b1) begin bad++; $display("[TB] FAIL relock_early: got %b want 1", granted); end
    @(negedge clk);
    total++; if (granted !== 1'b0) begin bad++; $display("[TB] FAIL relock_granted: got %b want 0", granted); end
    total++; if (led !== 3'b111) begin bad++; $display("[TB] FAIL relock_led: got %b want 111", led); end
    enter_btn = 1'b0;
  endtask

  task automatic test_fail_lockout();
    int lat;
    int cd;
    int lk;
    int blink_bad;
    logic [2:0] exp_led;
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      fail_once(lat);
      total++; if (lat != 4) begin bad++; $display("[TB] FAIL fail%0d_latency: got %0d want 4", k, lat); end
      total++; if (fail_count !== 4'(k)) begin bad++; $display("[TB] FAIL fail%0d_count: got %0d want %0d", k, fail_count, k); end
      cd = 0;
      while (led === 3'b000 && cd < 40) begin
        cd++;
        @(negedge clk);
      end
      total++; if (cd != 16) begin bad++; $display("[TB] FAIL fail%0d_cooldown_len: got %0d want 16", k, cd); end
      total++; if (fail_count !== 4'(k)) begin bad++; $display("[TB] FAIL fail%0d_count_held: got %0d want %0d", k, fail_count, k); end
    end
    fail_once(lat);
    total++; if (fail_count !== 4'd3) begin bad++; $display("[TB] FAIL fail3_count: got %0d want 3", fail_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL fail3_locked: got %b want 1", locked); end
    lk = 0;
    blink_bad = 0;
    while (locked === 1'b1 && lk < 100) begin
      exp_led = (((lk / 4) % 2) == 0) ? 3'b110 : 3'b111;
      if (led !== exp_led) blink_bad++;
      lk++;
      @(negedge clk);
    end
    total++; if (lk != 64) begin bad++; $display("[TB] FAIL lockout_len: got %0d want 64", lk); end
    total++; if (blink_bad != 0) begin bad++; $display("[TB] FAIL lockout_blink: got %0d wrong cycles want 0", blink_bad); end
    total++; if (fail_count !== 4'd0) begin bad++; $display("[TB] FAIL lockout_exit_count: got %0d want 0", fail_count); end
    total++; if (led !== 3'b111) begin bad++; $display("[TB] FAIL lockout_exit_led: got %b want 111", led); end
  endtask

  // The timeout verdict is taken in the 32nd cycle after chk_start; COOLDOWN shows one cycle later.
  task automatic test_timeout();
    int lat;
    int t;
    do_reset();
    press_wait_start(lat);
    t = 0;
    while (fail_count === 4'd0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    total++; if (t != 33) begin bad++; $display("[TB] FAIL timeout_len: got %0d want 33", t); end
    total++; if (fail_count !== 4'd1) begin bad++; $display("[TB] FAIL timeout_count: got %0d want 1", fail_count); end
    total++; if (led !== 3'b000) begin bad++; $display("[TB] FAIL timeout_led: got %b want 000", led); end
    press_wait_start(lat);
    total++; if (lat != 4) begin bad++; $display("[TB] FAIL edge_latency: got %0d want 4", lat); end
    repeat (32) @(negedge clk);
    chk_done = 1'b1;
    chk_pass = 1'b1;
    @(negedge clk);
    chk_done = 1'b0;
    chk_pass = 1'b0;
    total++; if (granted !== 1'b1) begin bad++; $display("[TB] FAIL edge_pass_granted: got %b want 1", granted); end
    total++; if (fail_count !== 4'd0) begin bad++; $display("[TB] FAIL edge_pass_count: got %0d want 0", fail_count); end
  endtask

  task automatic test_discard();
    int lat;
    int seen;
    do_reset();
    fail_once(lat);
    enter_btn = 1'b1;
    seen = 0;
    for (int i = 0; i < 26; i++) begin
      if (i == 8) enter_btn = 1'b0;
      @(negedge clk);
      if (chk_start === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL cooldown_discard: got %0d starts want 0", seen); end
    fail_once(lat);
    fail_once(lat);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL discard_locked: got %b want 1", locked); end
    enter_btn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) enter_btn = 1'b0;
      @(negedge clk);
      if (chk_start === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL lockout_discard: got %0d starts want 0", seen); end
    rst = 1'b1;
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL rst_lockout_locked: got %b want 0", locked); end
    total++; if (led !== 3'b111) begin bad++; $display("[TB] FAIL rst_lockout_led: got %b want 111", led); end
    total++; if (fail_count !== 4'd0) begin bad++; $display("[TB] FAIL rst_lockout_count: got %0d want 0", fail_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (chk_start === 1'b1 || locked === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL rst_lockout_residue: got %0d events want 0", seen); end
  endtask

  task automatic test_glitch();
    int lat;
    do_reset();
    press_wait_start(lat);
    @(negedge clk);
    glitch_btn = 1'b1;
    repeat (2) @(negedge clk);
    chk_done = 1'b1;
    chk_pass = 1'b1;
    @(negedge clk);
    chk_done = 1'b0;
    chk_pass = 1'b0;
    glitch_btn = 1'b0;
`ifdef GLITCH_GUARD_EN
    total++; if (fail_count !== 4'd1) begin bad++; $display("[TB] FAIL glitch_count: got %0d want 1", fail_count); end
    total++; if (granted !== 1'b0) begin bad++; $display("[TB] FAIL glitch_granted: got %b want 0", granted); end
`else
    total++; if (fail_count !== 4'd0) begin bad++; $display("[TB] FAIL glitch_count: got %0d want 0", fail_count); end
    total++; if (granted !== 1'b1) begin bad++; $display("[TB] FAIL glitch_granted: got %b want 1", granted); end
`endif
  endtask

  initial begin
    test_reset();
    test_grant();
    test_fail_lockout();
    test_timeout();
    test_discard();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
